// File: rtl/reg_bus_arb_pkg.sv
// Shared types and defaults for the register-bus arbiter slice.
package reg_bus_arb_pkg;

    // Default bus geometry; the arbiter takes these as parameter defaults.
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Round-robin pointer advance: the slot after the winner, wrapping to 0.
    function automatic int next_ptr(input int idx, input int n);
        int nxt;
        if (idx >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Scan NUM_REQ slots starting at the pointer; the first hit wins.
    always_comb begin
        int pos;
        int pos_w;
        valid  = 1'b0;
        winner = {IDX_W{1'b0}};
        pos    = 0;
        pos_w  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos_w = pos - NUM_REQ;
            end else begin
                pos_w = pos;
            end
            if (!valid && req[pos_w]) begin
                valid  = 1'b1;
                winner = pos_w[IDX_W-1:0];
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between NUM_REQ requesters.
// IDLE picks and latches a winner, ACCESS drives bus_en for one cycle,
// DONE returns the ack (and read data) and advances the pointer.
module reg_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = reg_bus_arb_pkg::ADDR_W,
    parameter int DATA_W  = reg_bus_arb_pkg::DATA_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        busy_o,
    output logic [IDX_W-1:0]            grant_idx_o,
    output logic                        bus_en,
    output logic                        bus_wr,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wdata,
    input  logic [DATA_W-1:0]           bus_rdata
);

    import reg_bus_arb_pkg::*;

    localparam logic [NUM_REQ-1:0] ACK_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e         state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req_i),
        .ptr    (ptr_r),
        .valid  (pick_valid_s),
        .winner (pick_idx_s)
    );

    // Access sequencer; every output is a register. The winner's fields are
    // captured straight into the bus registers, which then hold until the
    // next grant. bus_rdata is sampled on the edge that closes the enable
    // cycle so rdata_o lines up with the ack pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            ack_o       <= {NUM_REQ{1'b0}};
            rdata_o     <= {DATA_W{1'b0}};
            busy_o      <= 1'b0;
            grant_idx_o <= {IDX_W{1'b0}};
            bus_en      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= {ADDR_W{1'b0}};
            bus_wdata   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ack_o <= {NUM_REQ{1'b0}};
                    if (pick_valid_s) begin
                        grant_idx_o <= pick_idx_s;
                        bus_en      <= 1'b1;
                        bus_wr      <= req_wr_i[pick_idx_s];
                        bus_addr    <= req_addr_i[pick_idx_s*ADDR_W +: ADDR_W];
                        bus_wdata   <= req_wdata_i[pick_idx_s*DATA_W +: DATA_W];
                        busy_o      <= 1'b1;
                        state_r     <= ACCESS;
                    end else begin
                        bus_en      <= 1'b0;
                        busy_o      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                ACCESS: begin
                    bus_en  <= 1'b0;
                    ack_o   <= ACK_LSB << grant_idx_o;
                    if (!bus_wr) begin
                        rdata_o <= bus_rdata;
                    end else begin
                        rdata_o <= rdata_o;
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    ack_o   <= {NUM_REQ{1'b0}};
                    busy_o  <= 1'b0;
                    ptr_r   <= IDX_W'(next_ptr(int'(grant_idx_o), NUM_REQ));
                    state_r <= IDLE;
                end
                default: begin
                    ack_o   <= {NUM_REQ{1'b0}};
                    bus_en  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: stimulus pushes expected grants,
// a negedge monitor checks every bus cycle and every ack against them.
module tb_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_i;
    logic [3:0]  req_wr_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  ack_o;
    logic [7:0]  rdata_o;
    logic        busy_o;
    logic [1:0]  grant_idx_o;
    logic        bus_en;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    logic [7:0]  mem [256];

    typedef struct {
        int         idx;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ack = -1;
    bit spacing_on = 1'b0;
    bit prev_en = 1'b0;
    logic [3:0] exp_ack;

    reg_bus_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req_i),
        .req_wr_i    (req_wr_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .grant_idx_o (grant_idx_o),
        .bus_en      (bus_en),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    // Cycle counter for ack spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Simple register slave: combinational read, write on the enable edge.
    assign bus_rdata = mem[bus_addr];
    always @(posedge clk) begin
        if (bus_en && bus_wr) mem[bus_addr] <= bus_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata);
        exp_t e;
        e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sbq.push_back(e);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bus_en"},    32'(bus_en),      32'd0);
        chk({tag, "_bus_wr"},    32'(bus_wr),      32'd0);
        chk({tag, "_bus_addr"},  32'(bus_addr),    32'd0);
        chk({tag, "_bus_wdata"}, 32'(bus_wdata),   32'd0);
        chk({tag, "_ack"},       32'(ack_o),       32'd0);
        chk({tag, "_rdata"},     32'(rdata_o),     32'd0);
        chk({tag, "_busy"},      32'(busy_o),      32'd0);
        chk({tag, "_grant"},     32'(grant_idx_o), 32'd0);
    endtask

    // Requester k: present fields, hold req for n grants, drop after the last ack.
    task automatic do_req(input int k, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int n, input int exp_lat);
        int  waited;
        bit  got;
        @(posedge clk); #1;
        req_wr_i[k] = wr;
        req_addr_i[k*8 +: 8] = addr;
        req_wdata_i[k*8 +: 8] = wdata;
        req_i[k] = 1'b1;
        for (int g = 0; g < n; g++) begin
            waited = 0;
            got = 1'b0;
            while (!got && waited < 200) begin
                @(negedge clk);
                waited++;
                if (ack_o[k]) got = 1'b1;
            end
            if (!got) begin
                chk($sformatf("ack_timeout_req%0d", k), 32'd0, 32'd1);
                break;
            end
            if (exp_lat > 0 && g == 0) chk($sformatf("latency_req%0d", k), 32'(waited), 32'(exp_lat));
            @(posedge clk); #1;
        end
        req_i[k] = 1'b0;
    endtask

    // Monitor: bus cycles checked against the head entry, acks pop it.
    always @(negedge clk) begin
        if (!rstn) begin
            last_ack = -1;
            prev_en  = 1'b0;
        end else begin
            if (bus_en) begin
                chk("bus_en_single", 32'(prev_en), 32'd0);
                chk("busy_in_access", 32'(busy_o), 32'd1);
                if (sbq.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("bus_addr", 32'(bus_addr), 32'(sbq[0].addr));
                    chk("bus_wr", 32'(bus_wr), 32'(sbq[0].wr));
                    if (sbq[0].wr) chk("bus_wdata", 32'(bus_wdata), 32'(sbq[0].wdata));
                end
            end
            prev_en = bus_en;
            if (ack_o != 4'd0) begin
                if (sbq.size() == 0) begin
                    chk("ack_unexpected", 32'(ack_o), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    exp_ack = 4'b0001 << mon_e.idx;
                    chk("ack_onehot", 32'(ack_o), 32'(exp_ack));
                    chk("grant_idx", 32'(grant_idx_o), 32'(mon_e.idx));
                    chk("rdata", 32'(rdata_o), 32'(mon_e.rdata));
                    chk("busy_in_done", 32'(busy_o), 32'd1);
                    chk("bus_en_off_in_done", 32'(bus_en), 32'd0);
                    if (spacing_on && last_ack >= 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd3);
                end
                last_ack = cyc;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        rstn = 1'b0;
        req_i = 4'd0;
        req_wr_i = 4'd0;
        req_addr_i = 32'd0;
        req_wdata_i = 32'd0;
        #3;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single write, then single read of the same address.
        push(0, 1'b1, 8'h10, 8'hA5, 8'h00);
        do_req(0, 1'b1, 8'h10, 8'hA5, 1, 3);
        push(2, 1'b0, 8'h10, 8'h00, 8'hA5);
        do_req(2, 1'b0, 8'h10, 8'h00, 1, 3);

        // Round-robin: all four requesting continuously out of reset.
        rstn = 1'b0;
        spacing_on = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push(0, 1'b1, 8'h80, 8'h11, 8'h00 | ((r == 0) ? 8'h00 : 8'h33));
            push(1, 1'b0, 8'h80, 8'h00, 8'h11);
            push(2, 1'b1, 8'h82, 8'h33, 8'h11);
            push(3, 1'b0, 8'h82, 8'h00, 8'h33);
        end
        fork
            do_req(0, 1'b1, 8'h80, 8'h11, 3, 0);
            do_req(1, 1'b0, 8'h80, 8'h00, 3, 0);
            do_req(2, 1'b1, 8'h82, 8'h33, 3, 0);
            do_req(3, 1'b0, 8'h82, 8'h00, 3, 0);
            begin
                repeat (3) @(posedge clk);
                #2 rstn = 1'b1;
            end
        join
        spacing_on = 1'b0;

        // Pointer wrapped to 0 after grant 3: req1 beats req3.
        push(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        push(3, 1'b1, 8'h90, 8'h77, 8'hA5);
        fork
            do_req(1, 1'b0, 8'h10, 8'h00, 1, 0);
            do_req(3, 1'b1, 8'h90, 8'h77, 1, 0);
        join

        // Late address change after capture is ignored.
        push(1, 1'b1, 8'h20, 8'h3C, 8'hA5);
        fork
            do_req(1, 1'b1, 8'h20, 8'h3C, 1, 3);
            begin
                repeat (2) @(posedge clk);
                #2 req_addr_i[15:8] = 8'h30;
            end
        join
        push(0, 1'b0, 8'h20, 8'h00, 8'h3C);
        do_req(0, 1'b0, 8'h20, 8'h00, 1, 3);

        // Reset during ACCESS: no ack, re-granted after release.
        push(2, 1'b1, 8'h44, 8'h5A, 8'h00);
        fork
            do_req(2, 1'b1, 8'h44, 8'h5A, 1, 0);
            begin
                int w;
                w = 0;
                while (!bus_en && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                chk("reset_reach_access", 32'(bus_en), 32'd1);
                #2 rstn = 1'b0;
                #1 chk_outputs_zero("midreset");
                repeat (2) @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        push(3, 1'b0, 8'h44, 8'h00, 8'h5A);
        do_req(3, 1'b0, 8'h44, 8'h00, 1, 3);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
